// File: rtl/busy_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : busy_timer_pkg
// Description : Shared constants for busy_timer: the 2-bit operating mode
//               codes and the IDLE/RUN state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package busy_timer_pkg;

    // Operating modes, sampled on an accepted start. Code 3 is reserved and
    // behaves as ONESHOT because only RETRIGGER and PERIODIC are compared.
    localparam logic [1:0] c_mode_oneshot   = 2'd0;
    localparam logic [1:0] c_mode_retrigger = 2'd1;
    localparam logic [1:0] c_mode_periodic  = 2'd2;

    // Timer state encoding.
    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

endpackage : busy_timer_pkg
`default_nettype wire

// File: rtl/busy_timer.sv
`default_nettype none
// ============================================================================
// Module      : busy_timer
// Description : Retriggerable busy/period timer. Produces a busy window of
//               programmable length in ONESHOT, RETRIGGER or PERIODIC mode,
//               with abort and a one-cycle end-of-window pulse.
// Ports       : i_clk    - clock, rising edge
//               i_reset  - synchronous active-high reset
//               i_start  - start / retrigger request
//               i_abort  - end the current window immediately (no o_done)
//               i_load   - write i_count into the length register
//               i_count  - new window length
//               i_mode   - 0 ONESHOT, 1 RETRIGGER, 2 PERIODIC, 3 as ONESHOT
//               o_busy   - window active
//               o_done   - pulse in the final busy cycle of each window
//               o_count  - remaining cycles after this one, 0 when idle
// Revision    : 1.0 - initial release
// ============================================================================
module busy_timer
    import busy_timer_pkg::*;
#(
    parameter int LGMAX         = 16,
    parameter int DEFAULT_COUNT = 22
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_load,
    input  logic [LGMAX-1:0] i_count,
    input  logic [1:0]       i_mode,
    output logic             o_busy,
    output logic             o_done,
    output logic [LGMAX-1:0] o_count
);

    localparam logic [LGMAX-1:0] c_zero    = '0;
    localparam logic [LGMAX-1:0] c_one     = LGMAX'(1);
    localparam logic [LGMAX-1:0] c_default = LGMAX'(DEFAULT_COUNT);

    logic [0:0]       r_state;
    logic [LGMAX-1:0] r_counter;
    logic [LGMAX-1:0] r_len;
    logic [1:0]       r_mode;

    logic [0:0]       w_state_nxt;
    logic [LGMAX-1:0] w_counter_nxt;
    logic [1:0]       w_mode_nxt;
    logic [LGMAX-1:0] w_leff;
    logic             w_leff_nz;

    // A length written this cycle takes effect immediately for any start,
    // retrigger or periodic reload happening in the same cycle.
    assign w_leff    = i_load ? i_count : r_len;
    assign w_leff_nz = (w_leff != c_zero);

    always_comb begin
        w_state_nxt   = r_state;
        w_counter_nxt = r_counter;
        w_mode_nxt    = r_mode;

        if (i_abort) begin
            w_state_nxt   = c_st_idle;
            w_counter_nxt = c_zero;
        end else if (r_state == c_st_idle) begin
            if (i_start && w_leff_nz) begin
                w_state_nxt   = c_st_run;
                w_counter_nxt = w_leff - c_one;
                w_mode_nxt    = i_mode;
            end
        end else if (i_start && (r_mode == c_mode_retrigger)) begin
            // Retrigger restarts the window; a zero length ends it instead.
            if (w_leff_nz) begin
                w_counter_nxt = w_leff - c_one;
            end else begin
                w_state_nxt   = c_st_idle;
                w_counter_nxt = c_zero;
            end
        end else if (r_counter != c_zero) begin
            w_counter_nxt = r_counter - c_one;
        end else if ((r_mode == c_mode_periodic) && w_leff_nz) begin
            w_counter_nxt = w_leff - c_one;
        end else begin
            w_state_nxt   = c_st_idle;
            w_counter_nxt = c_zero;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= c_st_idle;
            r_counter <= c_zero;
            r_len     <= c_default;
            r_mode    <= c_mode_oneshot;
        end else begin
            r_state   <= w_state_nxt;
            r_counter <= w_counter_nxt;
            r_mode    <= w_mode_nxt;
            if (i_load) begin
                r_len <= i_count;
            end
        end
    end

    // Outputs come straight from registers: no input-to-output path.
    assign o_busy  = (r_state == c_st_run);
    assign o_done  = (r_state == c_st_run) && (r_counter == c_zero);
    assign o_count = r_counter;

endmodule : busy_timer
`default_nettype wire

// File: tb/tb_busy_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_busy_timer
// Description : Self-checking bench for busy_timer. A default-width instance
//               is compared against a window-end-time reference model; a
//               4-bit instance exercises the maximum-length boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_busy_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, abort = 1'b0, load = 1'b0;
    logic [15:0] count = '0;
    logic [1:0]  mode = '0;
    logic        busy, done;
    logic [15:0] ocount;

    logic        s_start = 1'b0, s_abort = 1'b0, s_load = 1'b0;
    logic [3:0]  s_count = '0;
    logic        s_busy, s_done;
    logic [3:0]  s_ocount;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    busy_timer #(.LGMAX(16), .DEFAULT_COUNT(22)) u_dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_abort(abort),
        .i_load(load), .i_count(count), .i_mode(mode),
        .o_busy(busy), .o_done(done), .o_count(ocount)
    );

    busy_timer #(.LGMAX(4), .DEFAULT_COUNT(3)) u_small (
        .i_clk(clk), .i_reset(rst), .i_start(s_start), .i_abort(s_abort),
        .i_load(s_load), .i_count(s_count), .i_mode(2'd0),
        .o_busy(s_busy), .o_done(s_done), .o_count(s_ocount)
    );

    // Reference model: a window is the absolute cycle range ending at m_end.
    // m_t is the index of the cycle whose outputs are currently visible.
    bit       m_busy = 1'b0;
    int       m_t = 0;
    int       m_end = 0;
    int       m_len = 22;
    bit [1:0] m_mode = 2'd0;

    function automatic void model_edge();
        int leff;
        leff = load ? int'(count) : m_len;
        if (rst) begin
            m_busy = 1'b0; m_len = 22; m_mode = 2'd0;
        end else begin
            if (load) m_len = int'(count);
            if (abort) m_busy = 1'b0;
            else if (!m_busy) begin
                if (start && leff != 0) begin
                    m_busy = 1'b1; m_end = m_t + leff; m_mode = mode;
                end
            end else if (start && m_mode == 2'd1) begin
                if (leff == 0) m_busy = 1'b0;
                else m_end = m_t + leff;
            end else if (m_t == m_end) begin
                if (m_mode == 2'd2 && leff != 0) m_end = m_t + leff;
                else m_busy = 1'b0;
            end
        end
        m_t++;
    endfunction

    function automatic logic exp_busy();
        return m_busy;
    endfunction
    function automatic logic exp_done();
        return m_busy && (m_t == m_end);
    endfunction
    function automatic logic [15:0] exp_count();
        return m_busy ? 16'(m_end - m_t) : 16'd0;
    endfunction

    // Advance one clock; outputs are examined 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        start = 0; abort = 0; load = 0; rst = 0;
        s_start = 0; s_abort = 0; s_load = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1; tick(); tick(); rst = 0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ocount !== 16'd0) begin
            errors++;
            $display("FAIL reset: busy/done/count got %b/%b/%0d want 0/0/0", busy, done, ocount);
        end
        checks++;
        if (s_busy !== 1'b0 || s_done !== 1'b0 || s_ocount !== 4'd0) begin
            errors++;
            $display("FAIL reset_small: busy/done/count got %b/%b/%0d want 0/0/0", s_busy, s_done, s_ocount);
        end
    endtask

    task automatic test_oneshot_default();
        int nbusy = 0, ndone = 0, done_at = -1;
        mode = 2'd0; start = 1; tick(); start = 0;
        for (int c = 1; c <= 24; c++) begin
            checks++;
            if (busy !== exp_busy() || done !== exp_done() || ocount !== exp_count()) begin
                errors++;
                $display("FAIL oneshot cyc %0d: got %b/%b/%0d want %b/%b/%0d",
                         c, busy, done, ocount, exp_busy(), exp_done(), exp_count());
            end
            if (c == 1) begin
                checks++;
                if (ocount !== 16'd21) begin
                    errors++;
                    $display("FAIL oneshot_first_count: got %0d want 21", ocount);
                end
            end
            if (busy === 1'b1) nbusy++;
            if (done === 1'b1) begin ndone++; done_at = c; end
            tick();
        end
        checks++;
        if (nbusy != 22 || ndone != 1 || done_at != 22) begin
            errors++;
            $display("FAIL oneshot_window: busy %0d done %0d at %0d want 22/1/22", nbusy, ndone, done_at);
        end
    endtask

    task automatic test_periodic_abort();
        int ndone = 0;
        load = 1; count = 16'd5; mode = 2'd2; start = 1; tick();
        load = 0; start = 0;
        for (int c = 1; c <= 16; c++) begin
            checks++;
            if (busy !== exp_busy() || done !== exp_done() || ocount !== exp_count()) begin
                errors++;
                $display("FAIL periodic cyc %0d: got %b/%b/%0d want %b/%b/%0d",
                         c, busy, done, ocount, exp_busy(), exp_done(), exp_count());
            end
            if (c == 13) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL periodic_abort: busy at 13 got %b want 0", busy);
                end
            end
            if (done === 1'b1) ndone++;
            abort = (c == 12);
            tick();
            abort = 0;
        end
        checks++;
        if (ndone != 2) begin
            errors++;
            $display("FAIL periodic_done_count: got %0d want 2", ndone);
        end
    endtask

    task automatic test_retrigger();
        int nbusy = 0, ndone = 0, done_at = -1;
        load = 1; count = 16'd8; mode = 2'd1; start = 1; tick();
        load = 0; start = 0;
        for (int c = 1; c <= 17; c++) begin
            checks++;
            if (busy !== exp_busy() || done !== exp_done() || ocount !== exp_count()) begin
                errors++;
                $display("FAIL retrigger cyc %0d: got %b/%b/%0d want %b/%b/%0d",
                         c, busy, done, ocount, exp_busy(), exp_done(), exp_count());
            end
            if (busy === 1'b1) nbusy++;
            if (done === 1'b1) begin ndone++; done_at = c; end
            start = (c == 6);
            tick();
            start = 0;
        end
        checks++;
        if (nbusy != 14 || ndone != 1 || done_at != 14) begin
            errors++;
            $display("FAIL retrigger_window: busy %0d done %0d at %0d want 14/1/14", nbusy, ndone, done_at);
        end
    endtask

    task automatic test_oneshot_ignore_and_zero();
        int done_at = -1, nbusy = 0;
        load = 1; count = 16'd8; mode = 2'd0; start = 1; tick();
        load = 0; start = 0;
        for (int c = 1; c <= 10; c++) begin
            checks++;
            if (busy !== exp_busy() || done !== exp_done() || ocount !== exp_count()) begin
                errors++;
                $display("FAIL ignore cyc %0d: got %b/%b/%0d want %b/%b/%0d",
                         c, busy, done, ocount, exp_busy(), exp_done(), exp_count());
            end
            if (done === 1'b1) done_at = c;
            start = (c == 3);
            tick();
            start = 0;
        end
        checks++;
        if (done_at != 8) begin
            errors++;
            $display("FAIL ignore_done: done at %0d want 8", done_at);
        end
        load = 1; count = 16'd0; tick(); load = 0;
        start = 1; tick(); start = 0;
        for (int c = 0; c < 4; c++) begin
            if (busy === 1'b1 || done === 1'b1) nbusy++;
            tick();
        end
        checks++;
        if (nbusy != 0 || exp_busy() !== 1'b0) begin
            errors++;
            $display("FAIL zero_len: active cycles got %0d want 0", nbusy);
        end
    endtask

    task automatic test_reset_mid();
        int nbusy = 0;
        load = 1; count = 16'd10; mode = 2'd0; start = 1; tick();
        load = 0; start = 0;
        for (int c = 1; c <= 6; c++) begin
            checks++;
            if (busy !== exp_busy() || done !== exp_done() || ocount !== exp_count()) begin
                errors++;
                $display("FAIL reset_mid cyc %0d: got %b/%b/%0d want %b/%b/%0d",
                         c, busy, done, ocount, exp_busy(), exp_done(), exp_count());
            end
            if (c >= 5) begin
                checks++;
                if (busy !== 1'b0 || done !== 1'b0 || ocount !== 16'd0) begin
                    errors++;
                    $display("FAIL reset_mid_outputs cyc %0d: got %b/%b/%0d want 0/0/0", c, busy, done, ocount);
                end
            end
            rst = (c == 4);
            tick();
            rst = 0;
        end
        // Length register must be back at its default of 22.
        mode = 2'd0; start = 1; tick(); start = 0;
        for (int c = 0; c < 25; c++) begin
            if (busy === 1'b1) nbusy++;
            tick();
        end
        checks++;
        if (nbusy != 22) begin
            errors++;
            $display("FAIL reset_len: busy cycles got %0d want 22", nbusy);
        end
    endtask

    task automatic test_small_width();
        s_load = 1; s_count = 4'd15; s_start = 1; s_abort = 1; tick();
        s_load = 0; s_start = 0; s_abort = 0;
        checks++;
        if (s_busy !== 1'b0 || s_done !== 1'b0) begin
            errors++;
            $display("FAIL small_start_abort: busy/done got %b/%b want 0/0", s_busy, s_done);
        end
        s_start = 1; tick(); s_start = 0;
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (s_busy !== 1'b1 || s_ocount !== 4'(14 - i) || s_done !== (i == 14)) begin
                errors++;
                $display("FAIL small_window cyc %0d: got %b/%b/%0d want 1/%b/%0d",
                         i + 1, s_busy, s_done, s_ocount, (i == 14), 14 - i);
            end
            tick();
        end
        checks++;
        if (s_busy !== 1'b0 || s_ocount !== 4'd0) begin
            errors++;
            $display("FAIL small_end: busy/count got %b/%0d want 0/0", s_busy, s_ocount);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 299) == 0);
            abort = ($urandom_range(0, 39) == 0);
            start = ($urandom_range(0, 3) == 0);
            load  = ($urandom_range(0, 7) == 0);
            count = 16'($urandom_range(0, 12));
            mode  = 2'($urandom_range(0, 3));
            tick();
            checks++;
            if (busy !== exp_busy() || done !== exp_done() || ocount !== exp_count()) begin
                errors++;
                $display("FAIL random cyc %0d: got %b/%b/%0d want %b/%b/%0d",
                         c, busy, done, ocount, exp_busy(), exp_done(), exp_count());
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_oneshot_default();
        test_periodic_abort();
        test_retrigger();
        test_oneshot_ignore_and_zero();
        test_reset_mid();
        test_small_width();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_busy_timer
`default_nettype wire
